// File: rtl/image_downsampler.sv
// image_downsampler: streams one D5M grayscale frame into a 28x28 8-bit image.
// A centred (OUT_DIM<<BLK_LOG2)-square window is averaged in square blocks of
// edge 2**BLK_LOG2. Each block mean is written to the image memory in raster order.
// Optional build macro: IMG_INVERT_EN writes 255-mean (white digit on black).
// Ports:
//   D5M_PIXCLK  pixel clock, all logic on posedge
//   rst_n       asynchronous active-low reset
//   iGray       12-bit gray pixel, qualified by iDVAL
//   iDVAL       pixel valid strobe
//   iFVAL       frame valid, rising edge starts a frame
//   iStart      capture request level from another clock domain
//   oWe/oWaddr/oWdata  image memory write port (address = by*OUT_DIM+bx)
//   oBusy       capture armed or in progress
//   oDone       one-cycle pulse after the final block write
module image_downsampler #(
  parameter int unsigned IMG_W    = 640,
  parameter int unsigned IMG_H    = 480,
  parameter int unsigned X0       = 96,
  parameter int unsigned Y0       = 16,
  parameter int unsigned BLK_LOG2 = 4,
  parameter int unsigned OUT_DIM  = 28
) (
  input  logic        D5M_PIXCLK,
  input  logic        rst_n,
  input  logic [11:0] iGray,
  input  logic        iDVAL,
  input  logic        iFVAL,
  input  logic        iStart,
  output logic        oWe,
  output logic [9:0]  oWaddr,
  output logic [7:0]  oWdata,
  output logic        oBusy,
  output logic        oDone
);

  localparam int unsigned PIX_W  = 12;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned COL_W  = $clog2(IMG_W);
  localparam int unsigned ROW_W  = $clog2(IMG_H);
  localparam int unsigned WIN    = OUT_DIM << BLK_LOG2;
  localparam int unsigned BX_W   = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
  localparam int unsigned OFF_W  = BLK_LOG2 + BX_W;
  localparam int unsigned HACC_W = PIX_W + BLK_LOG2;
  localparam int unsigned CRAM_W = PIX_W + 2 * BLK_LOG2;

  typedef enum logic [1:0] {IDLE, ARM, CAPTURE, DONE} state_t;

  state_t             state;
  logic [COL_W-1:0]   col;
  logic [ROW_W-1:0]   row;
  logic               fval_q;
  logic [2:0]         start_sync;
  logic [HACC_W-1:0]  hacc;
  logic [CRAM_W-1:0]  cram [OUT_DIM];

  logic               fval_rise_c;
  logic               fval_fall_c;
  logic               start_rise_c;
  logic               in_win_c;
  logic [OFF_W-1:0]   xoff_c;
  logic [OFF_W-1:0]   yoff_c;
  logic [BX_W-1:0]    bx_c;
  logic [BX_W-1:0]    by_c;
  logic [BLK_LOG2-1:0] cx_c;
  logic [BLK_LOG2-1:0] cy_c;
  logic               cx_last_c;
  logic               cy_last_c;
  logic               acc_en_c;
  logic [HACC_W-1:0]  row_sum_c;
  logic [CRAM_W-1:0]  blk_sum_c;
  logic               blk_done_c;
  logic               last_blk_c;
  logic [DATA_W-1:0]  pix_mean_c;

  // Edge detection on frame valid and on the synchronized start request
  always_comb begin
    fval_rise_c  = iFVAL & ~fval_q;
    fval_fall_c  = ~iFVAL & fval_q;
    start_rise_c = start_sync[1] & ~start_sync[2];
  end

  // Window membership, block indices and in-block offsets of the current pixel
  always_comb begin
    in_win_c  = (32'(col) >= X0) && (32'(col) < X0 + WIN) &&
                (32'(row) >= Y0) && (32'(row) < Y0 + WIN);
    xoff_c    = OFF_W'(32'(col) - X0);
    yoff_c    = OFF_W'(32'(row) - Y0);
    bx_c      = xoff_c[OFF_W-1:BLK_LOG2];
    by_c      = yoff_c[OFF_W-1:BLK_LOG2];
    cx_c      = xoff_c[BLK_LOG2-1:0];
    cy_c      = yoff_c[BLK_LOG2-1:0];
    cx_last_c = (cx_c == {BLK_LOG2{1'b1}});
    cy_last_c = (cy_c == {BLK_LOG2{1'b1}});
  end

  // Accumulation datapath; the block sum is only formed, never stored, on the last pixel
  always_comb begin
    acc_en_c   = (state == CAPTURE) && iDVAL && in_win_c;
    row_sum_c  = hacc + HACC_W'(iGray);
    blk_sum_c  = cram[bx_c] + CRAM_W'(row_sum_c);
    blk_done_c = acc_en_c && cx_last_c && cy_last_c;
    last_blk_c = blk_done_c && (bx_c == BX_W'(OUT_DIM - 1)) &&
                 (by_c == BX_W'(OUT_DIM - 1));
    pix_mean_c = blk_sum_c[CRAM_W-1 -: DATA_W];
  end

  // Raster position counters, restarted by each frame
  always_ff @(posedge D5M_PIXCLK or negedge rst_n) begin
    if (!rst_n) begin
      col    <= '0;
      row    <= '0;
      fval_q <= 1'b0;
    end else begin
      fval_q <= iFVAL;
      if (fval_rise_c) begin
        col <= '0;
        row <= '0;
      end else if (iDVAL) begin
        if (col == COL_W'(IMG_W - 1)) begin
          col <= '0;
          if (row != ROW_W'(IMG_H - 1)) row <= row + ROW_W'(1);
        end else begin
          col <= col + COL_W'(1);
        end
      end
    end
  end

  // Start request synchronizer plus edge-detect stage
  always_ff @(posedge D5M_PIXCLK or negedge rst_n) begin
    if (!rst_n) start_sync <= '0;
    else        start_sync <= {start_sync[1:0], iStart};
  end

  // Horizontal accumulator: restarts at the first pixel of each block row segment
  always_ff @(posedge D5M_PIXCLK or negedge rst_n) begin
    if (!rst_n) begin
      hacc <= '0;
    end else if (acc_en_c) begin
      hacc <= (cx_c == '0) ? HACC_W'(iGray) : row_sum_c;
    end
  end

  // Column RAM: per-block partial sums, contents meaningless until first line of a block
  always_ff @(posedge D5M_PIXCLK) begin
    if (acc_en_c && cx_last_c && !cy_last_c) begin
      cram[bx_c] <= (cy_c == '0) ? CRAM_W'(row_sum_c) : blk_sum_c;
    end
  end

  // Capture control and registered write port
  always_ff @(posedge D5M_PIXCLK or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      oWe    <= 1'b0;
      oWaddr <= '0;
      oWdata <= '0;
      oBusy  <= 1'b0;
      oDone  <= 1'b0;
    end else begin
      oWe   <= 1'b0;
      oDone <= 1'b0;
      case (state)
        IDLE: begin
          if (start_rise_c) begin
            state <= ARM;
            oBusy <= 1'b1;
          end
        end
        ARM: begin
          if (fval_rise_c) state <= CAPTURE;
        end
        CAPTURE: begin
          if (blk_done_c) begin
            oWe    <= 1'b1;
            oWaddr <= ADDR_W'(32'(by_c) * OUT_DIM + 32'(bx_c));
`ifdef IMG_INVERT_EN
            oWdata <= ~pix_mean_c;
`else
            oWdata <= pix_mean_c;
`endif
            if (last_blk_c) state <= DONE;
          end else if (fval_fall_c) begin
            // Frame ended early: wait for a whole new frame and restart at block 0
            state <= ARM;
          end
        end
        DONE: begin
          oDone <= 1'b1;
          oBusy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
